// File: rtl/rv32i_pkg.sv
// Shared RV32I decode definitions: widths, base opcodes, immediate formats and the ID/EX payload.
package rv32i_pkg;

   localparam int unsigned XLEN  = 32;
   localparam int unsigned REG_W = 5;
   localparam int unsigned OPC_W = 7;
   localparam int unsigned F3_W  = 3;

   localparam logic [OPC_W-1:0] OP     = 7'b0110011;
   localparam logic [OPC_W-1:0] OP_IMM = 7'b0010011;
   localparam logic [OPC_W-1:0] LOAD   = 7'b0000011;
   localparam logic [OPC_W-1:0] STORE  = 7'b0100011;
   localparam logic [OPC_W-1:0] BRANCH = 7'b1100011;
   localparam logic [OPC_W-1:0] JAL    = 7'b1101111;
   localparam logic [OPC_W-1:0] JALR   = 7'b1100111;
   localparam logic [OPC_W-1:0] LUI    = 7'b0110111;
   localparam logic [OPC_W-1:0] AUIPC  = 7'b0010111;
   localparam logic [OPC_W-1:0] FENCE  = 7'b0001111;
   localparam logic [OPC_W-1:0] SYSTEM = 7'b1110011;

   typedef enum logic [2:0] {
      IMM_I,
      IMM_S,
      IMM_B,
      IMM_U,
      IMM_J,
      IMM_NONE
   } imm_type_t;

   typedef struct packed {
      logic [XLEN-1:0]  pc;
      logic [XLEN-1:0]  rs1_val;
      logic [XLEN-1:0]  rs2_val;
      logic [XLEN-1:0]  imm;
      logic [REG_W-1:0] rd;
      logic [OPC_W-1:0] opcode;
      logic [F3_W-1:0]  funct3;
      logic             funct7b5;
      logic             is_load;
      logic             illegal;
   } id_ex_t;

endpackage

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; every format sign-extends from instr[31].
module imm_gen
   import rv32i_pkg::*;
(
   input  logic [XLEN-1:0] instr,
   input  imm_type_t       imm_type,
   output logic [XLEN-1:0] imm
);

   // The opcode field never contributes to an immediate.
   logic unused_opcode;
   assign unused_opcode = ^instr[6:0];

   always_comb begin : imm_mux
      imm = '0;
      case (imm_type)
         IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
         IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         IMM_U:   imm = {instr[31:12], 12'b0};
         IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default: imm = '0;
      endcase
   end

endmodule

// File: rtl/id_stage.sv
// RV32I decode stage: handshake with fetch, operand select, load-use/flush control, ID/EX register.
// Optional writeback-to-read bypass is enabled by defining ID_WB_BYPASS_EN.
module id_stage
   import rv32i_pkg::*;
#(
   parameter int unsigned XLEN           = 32,
   parameter bit          NOP_ON_ILLEGAL = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             if_valid,
   output logic             if_ready,
   input  logic [XLEN-1:0]  if_instr,
   input  logic [XLEN-1:0]  if_pc,
   output logic [REG_W-1:0] rs1,
   output logic [REG_W-1:0] rs2,
   input  logic [XLEN-1:0]  rf_data_1,
   input  logic [XLEN-1:0]  rf_data_2,
   input  logic             wb_we,
   input  logic [REG_W-1:0] wb_rd,
   input  logic [XLEN-1:0]  wb_data,
   input  logic             flush,
   output logic             id_valid,
   input  logic             id_ready,
   output logic [XLEN-1:0]  id_pc,
   output logic [XLEN-1:0]  id_rs1_val,
   output logic [XLEN-1:0]  id_rs2_val,
   output logic [XLEN-1:0]  id_imm,
   output logic [REG_W-1:0] id_rd,
   output logic [OPC_W-1:0] id_opcode,
   output logic [F3_W-1:0]  id_funct3,
   output logic             id_funct7b5,
   output logic             id_is_load,
   output logic             id_illegal
);

   logic [OPC_W-1:0] opcode;
   logic             legal;
   logic             rs1_used;
   logic             rs2_used;
   logic             is_load;
   imm_type_t        imm_type;
   logic [REG_W-1:0] rd_dec;
   logic [XLEN-1:0]  imm;
   logic [XLEN-1:0]  rs1_val;
   logic [XLEN-1:0]  rs2_val;
   logic             load_hit;
   logic             hazard;
   logic             capture;

   id_ex_t id_q;
   id_ex_t id_d;
   logic   valid_q;
   logic   valid_d;

   assign opcode  = if_instr[6:0];
   assign rs1     = if_instr[19:15];
   assign rs2     = if_instr[24:20];
   assign is_load = (opcode == LOAD);

   // Opcode classification: legality, source usage, immediate format, destination.
   always_comb begin : decode
      legal    = 1'b1;
      rs1_used = 1'b1;
      rs2_used = 1'b0;
      imm_type = IMM_NONE;
      rd_dec   = if_instr[11:7];
      case (opcode)
         OP:                 rs2_used = 1'b1;
         OP_IMM, LOAD, JALR: imm_type = IMM_I;
         STORE: begin
            imm_type = IMM_S;
            rs2_used = 1'b1;
            rd_dec   = '0;
         end
         BRANCH: begin
            imm_type = IMM_B;
            rs2_used = 1'b1;
            rd_dec   = '0;
         end
         LUI, AUIPC: begin
            imm_type = IMM_U;
            rs1_used = 1'b0;
         end
         JAL: begin
            imm_type = IMM_J;
            rs1_used = 1'b0;
         end
         FENCE, SYSTEM: begin
         end
         default: begin
            legal  = 1'b0;
            rd_dec = '0;
         end
      endcase
   end

   imm_gen u_imm_gen (
      .instr    (if_instr),
      .imm_type (imm_type),
      .imm      (imm)
   );

   assign load_hit = valid_q & id_q.is_load & (id_q.rd != '0) &
                     ((rs1_used & (rs1 == id_q.rd)) | (rs2_used & (rs2 == id_q.rd)));

`ifdef ID_WB_BYPASS_EN
   logic wb_hit_1;
   logic wb_hit_2;
   assign wb_hit_1 = wb_we & (wb_rd != '0) & (wb_rd == rs1);
   assign wb_hit_2 = wb_we & (wb_rd != '0) & (wb_rd == rs2);
   assign hazard   = load_hit;
`else
   // Without the bypass, wait one cycle for the register file to absorb the write.
   logic wb_stall;
   logic unused_wb_data;
   assign wb_stall       = wb_we & (wb_rd != '0) &
                           ((rs1_used & (wb_rd == rs1)) | (rs2_used & (wb_rd == rs2)));
   assign hazard         = load_hit | wb_stall;
   assign unused_wb_data = ^wb_data;
`endif

   // x0 reads as zero regardless of any pending write.
   always_comb begin : operand_sel
      rs1_val = rf_data_1;
      rs2_val = rf_data_2;
`ifdef ID_WB_BYPASS_EN
      if (wb_hit_1) rs1_val = wb_data;
      if (wb_hit_2) rs2_val = wb_data;
`endif
      if (rs1 == '0) rs1_val = '0;
      if (rs2 == '0) rs2_val = '0;
   end

   assign if_ready = rst_n & ~flush & ~hazard & (~valid_q | id_ready);
   assign capture  = if_valid & if_ready;

   // ID/EX next state; flush and capture are mutually exclusive through if_ready.
   always_comb begin : next_state
      id_d    = id_q;
      valid_d = valid_q;
      if (flush) begin
         valid_d = 1'b0;
      end else if (capture) begin
         id_d.pc       = if_pc;
         id_d.rs1_val  = rs1_val;
         id_d.rs2_val  = rs2_val;
         id_d.imm      = imm;
         id_d.rd       = rd_dec;
         id_d.opcode   = opcode;
         id_d.funct3   = if_instr[14:12];
         id_d.funct7b5 = if_instr[30];
         id_d.is_load  = is_load;
         id_d.illegal  = ~legal;
         valid_d       = ~(NOP_ON_ILLEGAL & ~legal);
      end else if (valid_q & id_ready) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin : id_ex_reg
      if (!rst_n) begin
         id_q    <= '0;
         valid_q <= 1'b0;
      end else begin
         id_q    <= id_d;
         valid_q <= valid_d;
      end
   end

   assign id_valid    = valid_q;
   assign id_pc       = id_q.pc;
   assign id_rs1_val  = id_q.rs1_val;
   assign id_rs2_val  = id_q.rs2_val;
   assign id_imm      = id_q.imm;
   assign id_rd       = id_q.rd;
   assign id_opcode   = id_q.opcode;
   assign id_funct3   = id_q.funct3;
   assign id_funct7b5 = id_q.funct7b5;
   assign id_is_load  = id_q.is_load;
   assign id_illegal  = id_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed self-checking bench for id_stage with a small register-file model.
module tb_id_stage;

   localparam logic [31:0] I_ADDI  = 32'hFFF00293; // addi x5,x0,-1
   localparam logic [31:0] I_LW    = 32'h0000A303; // lw   x6,0(x1)
   localparam logic [31:0] I_ADD76 = 32'h002303B3; // add  x7,x6,x2
   localparam logic [31:0] I_ADD13 = 32'h003180B3; // add  x1,x3,x3
   localparam logic [31:0] I_BEQ   = 32'hFE208EE3; // beq  x1,x2,-4
   localparam logic [31:0] I_JAL   = 32'h001000EF; // jal  x1,+2048
   localparam logic [31:0] I_LUI   = 32'hABCDE537; // lui  x10,0xABCDE
   localparam logic [31:0] I_ILL   = 32'h00000FFF; // opcode 0x7F
   localparam logic [31:0] I_ADDI8 = 32'h00600413; // addi x8,x0,6

   logic        clk;
   logic        rst_n;
   logic        if_valid;
   logic        if_ready;
   logic [31:0] if_instr;
   logic [31:0] if_pc;
   logic [4:0]  rs1;
   logic [4:0]  rs2;
   logic [31:0] rf_data_1;
   logic [31:0] rf_data_2;
   logic        wb_we;
   logic [4:0]  wb_rd;
   logic [31:0] wb_data;
   logic        flush;
   logic        id_valid;
   logic        id_ready;
   logic [31:0] id_pc;
   logic [31:0] id_rs1_val;
   logic [31:0] id_rs2_val;
   logic [31:0] id_imm;
   logic [4:0]  id_rd;
   logic [6:0]  id_opcode;
   logic [2:0]  id_funct3;
   logic        id_funct7b5;
   logic        id_is_load;
   logic        id_illegal;

   int checks = 0;
   int errors = 0;

   logic [31:0] regs [32];

   id_stage dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .if_valid    (if_valid),
      .if_ready    (if_ready),
      .if_instr    (if_instr),
      .if_pc       (if_pc),
      .rs1         (rs1),
      .rs2         (rs2),
      .rf_data_1   (rf_data_1),
      .rf_data_2   (rf_data_2),
      .wb_we       (wb_we),
      .wb_rd       (wb_rd),
      .wb_data     (wb_data),
      .flush       (flush),
      .id_valid    (id_valid),
      .id_ready    (id_ready),
      .id_pc       (id_pc),
      .id_rs1_val  (id_rs1_val),
      .id_rs2_val  (id_rs2_val),
      .id_imm      (id_imm),
      .id_rd       (id_rd),
      .id_opcode   (id_opcode),
      .id_funct3   (id_funct3),
      .id_funct7b5 (id_funct7b5),
      .id_is_load  (id_is_load),
      .id_illegal  (id_illegal)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Register file: preset during reset, written by the writeback port.
   always @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) regs[i] <= 32'h0;
         regs[1] <= 32'h0000_0100;
         regs[2] <= 32'h0000_0022;
         regs[3] <= 32'h0000_3333;
         regs[6] <= 32'h0000_0066;
      end else if (wb_we && wb_rd != 5'd0) begin
         regs[wb_rd] <= wb_data;
      end
   end

   assign rf_data_1 = (rs1 == 5'd0) ? 32'h0 : regs[rs1];
   assign rf_data_2 = (rs2 == 5'd0) ? 32'h0 : regs[rs2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst_n    = 1'b0;
      if_valid = 1'b1;
      if_instr = I_ADDI;
      if_pc    = 32'h100;
      wb_we    = 1'b0;
      wb_rd    = 5'd0;
      wb_data  = 32'h0;
      flush    = 1'b0;
      id_ready = 1'b1;

      // Reset held for two edges with a pending fetch
      tick();
      tick();
      chk("rst_id_valid", 32'(id_valid), 32'd0);
      chk("rst_if_ready", 32'(if_ready), 32'd0);
      chk("rst_id_pc", id_pc, 32'h0);
      chk("rst_id_imm", id_imm, 32'h0);
      chk("rst_id_rd", 32'(id_rd), 32'd0);
      chk("rst_id_rs1_val", id_rs1_val, 32'h0);
      chk("rst_id_opcode", 32'(id_opcode), 32'd0);
      chk("addi_rs1_addr", 32'(rs1), 32'd0);
      chk("addi_rs2_addr", 32'(rs2), 32'd31);

      // Release: ADDI x5,x0,-1 captured on the next edge
      rst_n = 1'b1;
      #1;
      chk("rel_if_ready", 32'(if_ready), 32'd1);
      tick();
      chk("addi_valid", 32'(id_valid), 32'd1);
      chk("addi_imm", id_imm, 32'hFFFF_FFFF);
      chk("addi_rd", 32'(id_rd), 32'd5);
      chk("addi_rs1_val", id_rs1_val, 32'h0);
      chk("addi_pc", id_pc, 32'h100);
      chk("addi_opcode", 32'(id_opcode), 32'h13);
      chk("addi_illegal", 32'(id_illegal), 32'd0);

      // Load-use with execute always ready
      if_instr = I_LW;
      if_pc    = 32'h104;
      tick();
      chk("lw_is_load", 32'(id_is_load), 32'd1);
      chk("lw_rd", 32'(id_rd), 32'd6);
      chk("lw_rs1_val", id_rs1_val, 32'h100);
      chk("lw_funct3", 32'(id_funct3), 32'd2);
      if_instr = I_ADD76;
      if_pc    = 32'h108;
      #1;
      chk("lu_stall_if_ready", 32'(if_ready), 32'd0);
      chk("add_rs1_addr", 32'(rs1), 32'd6);
      chk("add_rs2_addr", 32'(rs2), 32'd2);
      tick();
      chk("lu_bubble_valid", 32'(id_valid), 32'd0);
      chk("lu_after_if_ready", 32'(if_ready), 32'd1);
      tick();
      chk("add_valid", 32'(id_valid), 32'd1);
      chk("add_pc", id_pc, 32'h108);
      chk("add_rd", 32'(id_rd), 32'd7);
      chk("add_rs1_val", id_rs1_val, 32'h66);
      chk("add_rs2_val", id_rs2_val, 32'h22);

      // Load-use with execute back-pressure for three cycles
      if_instr = I_LW;
      if_pc    = 32'h10C;
      tick();
      if_instr = I_ADD76;
      if_pc    = 32'h110;
      id_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("bp_if_ready", 32'(if_ready), 32'd0);
         tick();
         chk("bp_hold_valid", 32'(id_valid), 32'd1);
         chk("bp_hold_pc", id_pc, 32'h10C);
         chk("bp_hold_is_load", 32'(id_is_load), 32'd1);
      end
      id_ready = 1'b1;
      #1;
      chk("bp_release_if_ready", 32'(if_ready), 32'd0);
      tick();
      chk("bp_bubble_valid", 32'(id_valid), 32'd0);
      tick();
      chk("bp_add_valid", 32'(id_valid), 32'd1);
      chk("bp_add_pc", id_pc, 32'h110);

      // Writeback to x3 in the same cycle as ADD x1,x3,x3 is presented
      if_instr = I_ADD13;
      if_pc    = 32'h114;
      wb_we    = 1'b1;
      wb_rd    = 5'd3;
      wb_data  = 32'h1234;
`ifdef ID_WB_BYPASS_EN
      #1;
      chk("wb_byp_if_ready", 32'(if_ready), 32'd1);
      tick();
      wb_we = 1'b0;
`else
      #1;
      chk("wb_stall_if_ready", 32'(if_ready), 32'd0);
      tick();
      wb_we = 1'b0;
      chk("wb_stall_bubble", 32'(id_valid), 32'd0);
      #1;
      chk("wb_after_if_ready", 32'(if_ready), 32'd1);
      tick();
`endif
      chk("wb_valid", 32'(id_valid), 32'd1);
      chk("wb_pc", id_pc, 32'h114);
      chk("wb_rs1_val", id_rs1_val, 32'h1234);
      chk("wb_rs2_val", id_rs2_val, 32'h1234);

      // Flush with a valid ID/EX entry and a pending fetch
      if_instr = I_BEQ;
      if_pc    = 32'h118;
      flush    = 1'b1;
      #1;
      chk("flush_if_ready", 32'(if_ready), 32'd0);
      tick();
      chk("flush_valid", 32'(id_valid), 32'd0);
      flush = 1'b0;
      #1;
      chk("post_flush_if_ready", 32'(if_ready), 32'd1);

      // Immediate formats
      tick();
      chk("beq_valid", 32'(id_valid), 32'd1);
      chk("beq_imm", id_imm, 32'hFFFF_FFFC);
      chk("beq_rd", 32'(id_rd), 32'd0);
      chk("beq_pc", id_pc, 32'h118);
      if_instr = I_JAL;
      if_pc    = 32'h11C;
      tick();
      chk("jal_imm", id_imm, 32'h0000_0800);
      chk("jal_rd", 32'(id_rd), 32'd1);
      if_instr = I_LUI;
      if_pc    = 32'h120;
      tick();
      chk("lui_imm", id_imm, 32'hABCD_E000);
      chk("lui_rd", 32'(id_rd), 32'd10);
      if_instr = I_ILL;
      if_pc    = 32'h124;
      tick();
      chk("ill_valid", 32'(id_valid), 32'd1);
      chk("ill_illegal", 32'(id_illegal), 32'd1);
      chk("ill_rd", 32'(id_rd), 32'd0);
      chk("ill_imm", id_imm, 32'h0);

      // Load followed by OP-IMM whose unused rs2 field matches the load rd
      if_instr = I_LW;
      if_pc    = 32'h128;
      tick();
      if_instr = I_ADDI8;
      if_pc    = 32'h12C;
      #1;
      chk("opimm_no_stall", 32'(if_ready), 32'd1);
      tick();
      chk("opimm_rd", 32'(id_rd), 32'd8);
      chk("opimm_imm", id_imm, 32'h6);
      chk("opimm_pc", id_pc, 32'h12C);

      // Drain: execute consumes the entry with no new fetch
      if_valid = 1'b0;
      tick();
      chk("drain_valid", 32'(id_valid), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
